branch_checkpoint_writer: RTL and testbench
===========================================

Name: branch_checkpoint_writer

Overview:
- Producer side of the branch-state checkpoint interface. At rename it snapshots the rename map, free-list head and active-list id of each dispatched branch into a circular checkpoint buffer.
- Records whether the branch's delay slot has been dispatched.
- Frees a checkpoint when its branch resolves correctly.
- Applies the pointer and valid restore values supplied by misprediction recovery.
- Its registered outputs drive the branch_state_ifc contents that the recovery logic reads.

Parameters:
BRANCH_NUM, 4, checkpoint slots; power of two.
REG_NUM, 32, architectural registers.
PHYS_REG_NUM, 64, physical registers.
ACTIVE_LIST_SIZE, 64, active-list entries; power of two.
Derived widths: BI=$clog2(BRANCH_NUM), PI=$clog2(PHYS_REG_NUM), AI=$clog2(ACTIVE_LIST_SIZE).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_req  in  1  branch renamed this cycle; upstream holds it while full=1
alloc_active_id  in  AI  active-list id of the branch
alloc_free_head  in  PI  free-list head after the branch renamed
alloc_rename_snapshot  in  REG_NUM*PI  rename map after the branch; reg r at [r*PI +: PI]
ds_dispatch  in  1  delay-slot instruction of the youngest checkpointed branch dispatched
resolve_valid  in  1  a branch resolved as correctly predicted
resolve_active_id  in  AI  active-list id of that branch
branch_miss  in  1  misprediction recovery this cycle
miss_write_pointer  in  BI  restored write pointer from recovery
miss_valid  in  BRANCH_NUM  restored valid vector from recovery
full  out  1  slot at write pointer occupied; alloc not accepted
cp_valid  out  BRANCH_NUM  slot valid
cp_ds_valid  out  BRANCH_NUM  delay slot of slot's branch dispatched
cp_branch_id  out  BRANCH_NUM*AI  per-slot active-list id
cp_free_head  out  BRANCH_NUM*PI  per-slot free-list head
cp_rename_buffer  out  BRANCH_NUM*REG_NUM*PI  per-slot rename map
cp_write_pointer  out  BI  next slot to allocate
cp_count  out  BI+1  popcount(cp_valid), combinational

Behaviour:
- One clock (clk), asynchronous active-low reset (rst_n).
- Reset clears every register: cp_valid, cp_ds_valid, cp_branch_id, cp_free_head, cp_rename_buffer, cp_write_pointer, internal ds_pending and ds_slot all go to 0. Consequently full=0 and cp_count=0.
- Reset asserted mid-operation discards all checkpoints immediately, with no clock needed.
- full = cp_valid[cp_write_pointer]. This is combinational; slots free out of order, so occupancy is tested at the pointer only.
- Allocation happens when alloc_req & !full & !branch_miss. On the next edge, at slot w=cp_write_pointer:
  - valid=1, ds_valid=0;
  - branch_id, free_head and rename_buffer are loaded from the alloc_* inputs;
  - cp_write_pointer = w+1, modulo BRANCH_NUM (wrap from BRANCH_NUM-1 to 0);
  - ds_pending=1, ds_slot=w.
  - Latency is 1 cycle: the checkpoint is visible on cp_* the cycle after acceptance.
- alloc_req while full=1 is ignored; no state changes.
- ds_dispatch & ds_pending & !branch_miss sets cp_ds_valid[ds_slot]=1 and clears ds_pending.
  - ds_dispatch with ds_pending=0 is ignored.
  - ds_dispatch in the same cycle as an allocation applies to the previous ds_slot, before the new allocation overwrites ds_slot.
- Resolve: find the slots with cp_valid[i] & cp_branch_id[i]==resolve_active_id. The lowest matching index gets cp_valid=0 next edge.
  - No match means no effect.
  - Payload fields are not cleared.
- branch_miss has priority over allocation and ds_dispatch:
  - cp_write_pointer <= miss_write_pointer;
  - cp_valid <= miss_valid & ~resolve_hit_onehot. A same-cycle resolve is still honoured.
  - Payload and cp_ds_valid of the surviving slots are unchanged.
  - ds_pending stays set only if miss_valid[ds_slot]=1 and ds_slot==miss_write_pointer-1, i.e. the mispredicted branch's delay slot is not yet dispatched. Otherwise ds_pending is cleared.
- Allocation and resolve in the same cycle both apply. If the resolve hits slot w while allocating w, which is only possible with the optional feature, the allocation wins and valid=1.

Optional Feature:
BRANCH_CKPT_BYPASS_EN
- Defined: full = cp_valid[cp_write_pointer] & !(resolve hit at cp_write_pointer). A slot freed by resolve is reallocatable in the same cycle.
- Undefined: full uses only registered cp_valid, so a freed slot becomes reusable one cycle later.

Test Plan:
- Reset, then alloc ids 5,9,12,20 on consecutive cycles -> cp_valid=4'b1111, cp_write_pointer=0, full=1, cp_count=4. A fifth alloc (id 33) is dropped: no change.
- Alloc id 5 with free_head=17 and map[3]=40, then ds_dispatch next cycle -> slot0: branch_id=5, free_head=17, rename[3]=40, ds_valid=1. A second ds_dispatch is ignored.
- Four slots full; resolve id 9 (slot1) -> cp_valid=4'b1101, full stays 1 (pointer at 0). Resolve id 5 -> full=0 next cycle; alloc id 40 lands in slot0.
- Slots 0-3 valid, pointer=0; branch_miss with miss_write_pointer=2, miss_valid=4'b0011 plus simultaneous alloc -> pointer=2, cp_valid=4'b0011, alloc ignored.
- Alloc slot1 (ds_pending); branch_miss with miss_write_pointer=2, miss_valid=4'b0011 -> ds_pending kept; next ds_dispatch sets cp_ds_valid[1]=1.
- With BRANCH_CKPT_BYPASS_EN: full at pointer 0, resolve slot0 id + alloc id 50 same cycle -> accepted, slot0 branch_id=50, valid=1. Without the macro: alloc dropped, slot0 valid=0.

Source files
------------

// File: rtl/branch_checkpoint_writer.sv
// Branch checkpoint producer: snapshots rename state per dispatched branch into a circular buffer.
// Define BRANCH_CKPT_BYPASS_EN to let a slot freed by resolve be reallocated in the same cycle.
module branch_checkpoint_writer #(
    parameter int BRANCH_NUM       = 4,
    parameter int REG_NUM          = 32,
    parameter int PHYS_REG_NUM     = 64,
    parameter int ACTIVE_LIST_SIZE = 64,
    localparam int BI = $clog2(BRANCH_NUM),
    localparam int PI = $clog2(PHYS_REG_NUM),
    localparam int AI = $clog2(ACTIVE_LIST_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             alloc_req,
    input  logic [AI-1:0]                    alloc_active_id,
    input  logic [PI-1:0]                    alloc_free_head,
    input  logic [REG_NUM*PI-1:0]            alloc_rename_snapshot,
    input  logic                             ds_dispatch,
    input  logic                             resolve_valid,
    input  logic [AI-1:0]                    resolve_active_id,
    input  logic                             branch_miss,
    input  logic [BI-1:0]                    miss_write_pointer,
    input  logic [BRANCH_NUM-1:0]            miss_valid,
    output logic                             full,
    output logic [BRANCH_NUM-1:0]            cp_valid,
    output logic [BRANCH_NUM-1:0]            cp_ds_valid,
    output logic [BRANCH_NUM*AI-1:0]         cp_branch_id,
    output logic [BRANCH_NUM*PI-1:0]         cp_free_head,
    output logic [BRANCH_NUM*REG_NUM*PI-1:0] cp_rename_buffer,
    output logic [BI-1:0]                    cp_write_pointer,
    output logic [BI:0]                      cp_count
);

    localparam int MW = REG_NUM * PI;
    localparam int CW = BI + 1;

    logic [BRANCH_NUM-1:0] valid_q, valid_d;
    logic [BRANCH_NUM-1:0] ds_valid_q, ds_valid_d;
    logic [AI-1:0]         bid_q [BRANCH_NUM];
    logic [AI-1:0]         bid_d [BRANCH_NUM];
    logic [PI-1:0]         fh_q  [BRANCH_NUM];
    logic [PI-1:0]         fh_d  [BRANCH_NUM];
    logic [MW-1:0]         map_q [BRANCH_NUM];
    logic [MW-1:0]         map_d [BRANCH_NUM];
    logic [BI-1:0]         wp_q, wp_d;
    logic [BI-1:0]         ds_slot_q, ds_slot_d;
    logic                  ds_pending_q, ds_pending_d;

    logic [BRANCH_NUM-1:0] hit_oh;
    logic [BI-1:0]         miss_prev;
    logic                  alloc_en;
    logic [CW-1:0]         count;

    // Lowest matching index wins when several live slots share an id.
    always_comb begin
        hit_oh = '0;
        for (int i = BRANCH_NUM - 1; i >= 0; i--) begin
            if (resolve_valid && valid_q[i] && (bid_q[i] == resolve_active_id)) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

`ifdef BRANCH_CKPT_BYPASS_EN
    assign full = valid_q[wp_q] & ~hit_oh[wp_q];
`else
    assign full = valid_q[wp_q];
`endif

    assign alloc_en  = alloc_req & ~full & ~branch_miss;
    assign miss_prev = miss_write_pointer - BI'(1);

    always_comb begin
        valid_d      = valid_q & ~hit_oh;
        ds_valid_d   = ds_valid_q;
        wp_d         = wp_q;
        ds_slot_d    = ds_slot_q;
        ds_pending_d = ds_pending_q;
        bid_d        = bid_q;
        fh_d         = fh_q;
        map_d        = map_q;

        if (branch_miss) begin
            valid_d      = miss_valid & ~hit_oh;
            wp_d         = miss_write_pointer;
            // Pending survives only if the mispredicted branch itself still awaits its delay slot.
            ds_pending_d = ds_pending_q & miss_valid[ds_slot_q] & (ds_slot_q == miss_prev);
        end else begin
            if (ds_dispatch && ds_pending_q) begin
                ds_valid_d[ds_slot_q] = 1'b1;
                ds_pending_d          = 1'b0;
            end
            if (alloc_en) begin
                valid_d[wp_q]    = 1'b1;
                ds_valid_d[wp_q] = 1'b0;
                bid_d[wp_q]      = alloc_active_id;
                fh_d[wp_q]       = alloc_free_head;
                map_d[wp_q]      = alloc_rename_snapshot;
                wp_d             = wp_q + BI'(1);
                ds_slot_d        = wp_q;
                ds_pending_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            ds_valid_q   <= '0;
            wp_q         <= '0;
            ds_slot_q    <= '0;
            ds_pending_q <= 1'b0;
            for (int i = 0; i < BRANCH_NUM; i++) begin
                bid_q[i] <= '0;
                fh_q[i]  <= '0;
                map_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            ds_valid_q   <= ds_valid_d;
            wp_q         <= wp_d;
            ds_slot_q    <= ds_slot_d;
            ds_pending_q <= ds_pending_d;
            bid_q        <= bid_d;
            fh_q         <= fh_d;
            map_q        <= map_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            count = count + CW'(valid_q[i]);
        end
    end

    assign cp_valid         = valid_q;
    assign cp_ds_valid      = ds_valid_q;
    assign cp_write_pointer = wp_q;
    assign cp_count         = count;

    for (genvar g = 0; g < BRANCH_NUM; g++) begin : g_flat
        assign cp_branch_id[g*AI +: AI]     = bid_q[g];
        assign cp_free_head[g*PI +: PI]     = fh_q[g];
        assign cp_rename_buffer[g*MW +: MW] = map_q[g];
    end

endmodule

// File: tb/tb_branch_checkpoint_writer.sv
// Directed table-driven bench for branch_checkpoint_writer (4 slots, 32 regs, 64 phys, 64 AL entries).
module tb_branch_checkpoint_writer;

    localparam int BN = 4;
    localparam int RN = 32;
    localparam int PI = 6;
    localparam int AI = 6;
    localparam int NV = 23;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_req;
    logic [AI-1:0]    alloc_active_id;
    logic [PI-1:0]    alloc_free_head;
    logic [RN*PI-1:0] alloc_rename_snapshot;
    logic             ds_dispatch;
    logic             resolve_valid;
    logic [AI-1:0]    resolve_active_id;
    logic             branch_miss;
    logic [1:0]       miss_write_pointer;
    logic [BN-1:0]    miss_valid;
    logic             full;
    logic [BN-1:0]    cp_valid;
    logic [BN-1:0]    cp_ds_valid;
    logic [BN*AI-1:0] cp_branch_id;
    logic [BN*PI-1:0] cp_free_head;
    logic [BN*RN*PI-1:0] cp_rename_buffer;
    logic [1:0]       cp_write_pointer;
    logic [2:0]       cp_count;

    int checks = 0;
    int failures = 0;

    branch_checkpoint_writer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alloc_req             (alloc_req),
        .alloc_active_id       (alloc_active_id),
        .alloc_free_head       (alloc_free_head),
        .alloc_rename_snapshot (alloc_rename_snapshot),
        .ds_dispatch           (ds_dispatch),
        .resolve_valid         (resolve_valid),
        .resolve_active_id     (resolve_active_id),
        .branch_miss           (branch_miss),
        .miss_write_pointer    (miss_write_pointer),
        .miss_valid            (miss_valid),
        .full                  (full),
        .cp_valid              (cp_valid),
        .cp_ds_valid           (cp_ds_valid),
        .cp_branch_id          (cp_branch_id),
        .cp_free_head          (cp_free_head),
        .cp_rename_buffer      (cp_rename_buffer),
        .cp_write_pointer      (cp_write_pointer),
        .cp_count              (cp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          alloc;
        logic [5:0]    aid;
        logic [5:0]    fh;
        logic [5:0]    r3;
        logic          ds;
        logic          rv;
        logic [5:0]    rid;
        logic          miss;
        logic [1:0]    mwp;
        logic [3:0]    mv;
        logic [3:0]    ev;
        logic [3:0]    eds;
        logic [1:0]    ewp;
        logic          ef;
        logic [2:0]    ecnt;
        logic [5:0]    ebid0;
        logic [5:0]    efh0;
        logic [5:0]    er3_0;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    task automatic idle();
        alloc_req             = 1'b0;
        alloc_active_id       = '0;
        alloc_free_head       = '0;
        alloc_rename_snapshot = '0;
        ds_dispatch           = 1'b0;
        resolve_valid         = 1'b0;
        resolve_active_id     = '0;
        branch_miss           = 1'b0;
        miss_write_pointer    = '0;
        miss_valid            = '0;
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        alloc_req             = v.alloc;
        alloc_active_id       = v.aid;
        alloc_free_head       = v.fh;
        alloc_rename_snapshot = '0;
        alloc_rename_snapshot[3*PI +: PI] = v.r3;
        ds_dispatch           = v.ds;
        resolve_valid         = v.rv;
        resolve_active_id     = v.rid;
        branch_miss           = v.miss;
        miss_write_pointer    = v.mwp;
        miss_valid            = v.mv;
        @(posedge clk);
        #1 idle();
        #1;
        chk("valid",   row, 32'(cp_valid),         32'(v.ev));
        chk("ds",      row, 32'(cp_ds_valid),      32'(v.eds));
        chk("wp",      row, 32'(cp_write_pointer), 32'(v.ewp));
        chk("full",    row, 32'(full),             32'(v.ef));
        chk("count",   row, 32'(cp_count),         32'(v.ecnt));
        chk("bid0",    row, 32'(cp_branch_id[AI-1:0]),          32'(v.ebid0));
        chk("fh0",     row, 32'(cp_free_head[PI-1:0]),          32'(v.efh0));
        chk("rename0", row, 32'(cp_rename_buffer[3*PI +: PI]),  32'(v.er3_0));
    endtask

    initial begin
        //             al aid fh  r3 ds rv rid ms mwp mv       ev       eds      ewp f cnt bid fh r3
        tbl[0]  = '{1'b1, 6'd5,  6'd17, 6'd40, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1, 6'd5,  6'd17, 6'd40};
        tbl[1]  = '{1'b1, 6'd9,  6'd18, 6'd1,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b0001, 2'd2, 1'b0, 3'd2, 6'd5,  6'd17, 6'd40};
        tbl[2]  = '{1'b1, 6'd12, 6'd19, 6'd2,  1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0111, 4'b0001, 2'd3, 1'b0, 3'd3, 6'd5,  6'd17, 6'd40};
        tbl[3]  = '{1'b1, 6'd20, 6'd20, 6'd3,  1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1111, 4'b0001, 2'd0, 1'b1, 3'd4, 6'd5,  6'd17, 6'd40};
        tbl[4]  = '{1'b1, 6'd33, 6'd63, 6'd63, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1111, 4'b0001, 2'd0, 1'b1, 3'd4, 6'd5,  6'd17, 6'd40};
        tbl[5]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1111, 4'b1001, 2'd0, 1'b1, 3'd4, 6'd5,  6'd17, 6'd40};
        tbl[6]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1111, 4'b1001, 2'd0, 1'b1, 3'd4, 6'd5,  6'd17, 6'd40};
        tbl[7]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 6'd9,  1'b0, 2'd0, 4'b0000, 4'b1101, 4'b1001, 2'd0, 1'b1, 3'd3, 6'd5,  6'd17, 6'd40};
        tbl[8]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 6'd5,  1'b0, 2'd0, 4'b0000, 4'b1100, 4'b1001, 2'd0, 1'b0, 3'd2, 6'd5,  6'd17, 6'd40};
        tbl[9]  = '{1'b1, 6'd40, 6'd21, 6'd41, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1101, 4'b1000, 2'd1, 1'b0, 3'd3, 6'd40, 6'd21, 6'd41};
        tbl[10] = '{1'b1, 6'd44, 6'd7,  6'd7,  1'b0, 1'b0, 6'd0,  1'b1, 2'd2, 4'b0011, 4'b0011, 4'b1000, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[11] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b1000, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[12] = '{1'b1, 6'd45, 6'd8,  6'd8,  1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0111, 4'b1000, 2'd3, 1'b0, 3'd3, 6'd40, 6'd21, 6'd41};
        tbl[13] = '{1'b1, 6'd46, 6'd9,  6'd9,  1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1, 3'd4, 6'd40, 6'd21, 6'd41};
        tbl[14] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  1'b1, 2'd1, 4'b0001, 4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1, 6'd40, 6'd21, 6'd41};
        tbl[15] = '{1'b1, 6'd30, 6'd10, 6'd10, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[16] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  1'b1, 2'd2, 4'b0011, 4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[17] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b0010, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[18] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b0010, 2'd2, 1'b0, 3'd2, 6'd40, 6'd21, 6'd41};
        tbl[19] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 6'd30, 1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0010, 2'd0, 1'b1, 3'd1, 6'd40, 6'd21, 6'd41};
`ifdef BRANCH_CKPT_BYPASS_EN
        tbl[20] = '{1'b1, 6'd50, 6'd22, 6'd42, 1'b0, 1'b1, 6'd40, 1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0010, 2'd1, 1'b0, 3'd1, 6'd50, 6'd22, 6'd42};
        tbl[21] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 6'd55, 1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0010, 2'd1, 1'b0, 3'd1, 6'd50, 6'd22, 6'd42};
        tbl[22] = '{1'b1, 6'd47, 6'd23, 6'd43, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2, 6'd50, 6'd22, 6'd42};
`else
        tbl[20] = '{1'b1, 6'd50, 6'd22, 6'd42, 1'b0, 1'b1, 6'd40, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0010, 2'd0, 1'b0, 3'd0, 6'd40, 6'd21, 6'd41};
        tbl[21] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 6'd55, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0010, 2'd0, 1'b0, 3'd0, 6'd40, 6'd21, 6'd41};
        tbl[22] = '{1'b1, 6'd47, 6'd23, 6'd43, 1'b0, 1'b0, 6'd0,  1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0010, 2'd1, 1'b0, 3'd1, 6'd47, 6'd23, 6'd43};
`endif

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", -1, 32'(cp_valid),         32'd0);
        chk("rst_ds",    -1, 32'(cp_ds_valid),      32'd0);
        chk("rst_wp",    -1, 32'(cp_write_pointer), 32'd0);
        chk("rst_full",  -1, 32'(full),             32'd0);
        chk("rst_count", -1, 32'(cp_count),         32'd0);
        chk("rst_bid0",  -1, 32'(cp_branch_id[AI-1:0]), 32'd0);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], i);
        end

        // Mid-cycle asynchronous reset must clear state without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", -2, 32'(cp_valid),         32'd0);
        chk("async_ds",    -2, 32'(cp_ds_valid),      32'd0);
        chk("async_wp",    -2, 32'(cp_write_pointer), 32'd0);
        chk("async_count", -2, 32'(cp_count),         32'd0);
        chk("async_bid0",  -2, 32'(cp_branch_id[AI-1:0]), 32'd0);
        chk("async_fh0",   -2, 32'(cp_free_head[PI-1:0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
